// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard (set at issue, cleared at writeback or flush).
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic                sb_flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_reg  [DEPTH];
  logic [XLEN-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [AW:0]      cnt_reg;
  logic [AW:0]      cnt_next;

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];

  genvar gi;

  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr
      assign wa[gi] = wr_addr[gi*AW +: AW];
      assign wd[gi] = wr_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Ascending port order, so the highest-index enabled port lands last and wins.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_next[r] = regs_reg[r];
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        regs_next[wa[j]] = wd[j];
      end
    end
    if (ZERO_REG != 0) begin
      regs_next[0] = '0;
    end
  end

  // Applied weakest-first: writeback clear, then issue set, then flush.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        busy_next[wa[j]] = 1'b0;
      end
    end
    if (sb_set_en) begin
      busy_next[sb_set_addr] = 1'b1;
    end
    if (sb_flush) begin
      busy_next = '0;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[r]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_reg[r] <= '0;
      end
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_reg[r] <= regs_next[r];
      end
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy_cnt = cnt_reg;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] word;

      assign addr = rd_addr[gi*AW +: AW];

      // Register 0 is forced to zero last so a bypass hit cannot override it.
      always_comb begin
        word = regs_reg[addr];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] == addr)) begin
              word = wd[j];
            end
          end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
          word = '0;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = word;
      assign rd_busy[gi]              = busy_reg[addr];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: a bypassing instance and a
// non-bypassing instance share all stimulus.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2*AW-1:0] rd_addr;
  logic [2*XLEN-1:0] rd_data, rd_data_nb;
  logic [1:0]      rd_busy, rd_busy_nb;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic            sb_set_en;
  logic [AW-1:0]   sb_set_addr;
  logic            sb_flush;
  logic [AW:0]     busy_cnt, busy_cnt_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .busy_cnt(busy_cnt)
  );

  regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .busy_cnt(busy_cnt_nb)
  );

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic            se;
    logic [AW-1:0]   sa;
    logic            fl;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic [1:0]      eb;
    logic [AW:0]     ec;
    logic [XLEN-1:0] enb;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [1:0] we, logic [AW-1:0] wa0, logic [XLEN-1:0] wd0,
                              logic [AW-1:0] wa1, logic [XLEN-1:0] wd1,
                              logic [AW-1:0] ra0, logic [AW-1:0] ra1,
                              logic se, logic [AW-1:0] sa, logic fl,
                              logic [XLEN-1:0] e0, logic [XLEN-1:0] e1,
                              logic [1:0] eb, logic [AW:0] ec, logic [XLEN-1:0] enb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.se = se; v.sa = sa; v.fl = fl;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec; v.enb = enb;
    return v;
  endfunction

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; sb_flush = 1'b0;
  endtask

  initial begin
    //            we     wa0 wd0           wa1 wd1           ra0 ra1 se sa fl  e0            e1            eb     ec  enb
    vecs[0]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        5,  0,  0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0);
    vecs[1]  = mk(2'b01, 5,  32'hDEADBEEF, 0,  32'h0,        5,  5,  0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 32'h0);
    vecs[2]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        5,  5,  0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 32'hDEADBEEF);
    vecs[3]  = mk(2'b01, 0,  32'h1,        0,  32'h0,        0,  0,  0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0);
    vecs[4]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        0,  5,  0, 0, 0, 32'h0,        32'hDEADBEEF, 2'b00, 0, 32'h0);
    vecs[5]  = mk(2'b01, 7,  32'h12345678, 0,  32'h0,        7,  7,  0, 0, 0, 32'h12345678, 32'h12345678, 2'b00, 0, 32'h0);
    vecs[6]  = mk(2'b10, 0,  32'h0,        7,  32'hA5A5A5A5, 7,  5,  0, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 0, 32'h12345678);
    vecs[7]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        7,  7,  0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 0, 32'hA5A5A5A5);
    vecs[8]  = mk(2'b11, 3,  32'h11,       3,  32'h22,       3,  3,  0, 0, 0, 32'h22,       32'h22,       2'b00, 0, 32'h0);
    vecs[9]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        3,  3,  0, 0, 0, 32'h22,       32'h22,       2'b00, 0, 32'h22);
    vecs[10] = mk(2'b00, 0,  32'h0,        0,  32'h0,        9,  9,  1, 9, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0);
    vecs[11] = mk(2'b00, 0,  32'h0,        0,  32'h0,        9,  0,  0, 0, 0, 32'h0,        32'h0,        2'b01, 1, 32'h0);
    vecs[12] = mk(2'b10, 0,  32'h0,        9,  32'h99,       9,  9,  0, 0, 0, 32'h99,       32'h99,       2'b11, 1, 32'h0);
    vecs[13] = mk(2'b00, 0,  32'h0,        0,  32'h0,        9,  9,  0, 0, 0, 32'h99,       32'h99,       2'b00, 0, 32'h99);
    vecs[14] = mk(2'b01, 9,  32'h77,       0,  32'h0,        9,  9,  1, 9, 0, 32'h77,       32'h77,       2'b00, 0, 32'h99);
    vecs[15] = mk(2'b00, 0,  32'h0,        0,  32'h0,        9,  9,  0, 0, 0, 32'h77,       32'h77,       2'b11, 1, 32'h77);
    vecs[16] = mk(2'b01, 9,  32'h77,       0,  32'h0,        1,  9,  1, 1, 0, 32'h0,        32'h77,       2'b10, 1, 32'h0);
    vecs[17] = mk(2'b00, 0,  32'h0,        0,  32'h0,        1,  9,  1, 2, 0, 32'h0,        32'h77,       2'b01, 1, 32'h0);
    vecs[18] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2,  3,  1, 3, 0, 32'h0,        32'h22,       2'b01, 2, 32'h0);
    vecs[19] = mk(2'b00, 0,  32'h0,        0,  32'h0,        3,  4,  1, 4, 1, 32'h22,       32'h0,        2'b01, 3, 32'h22);
    vecs[20] = mk(2'b00, 0,  32'h0,        0,  32'h0,        4,  1,  0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0);
    vecs[21] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0,  0,  1, 0, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0);
    vecs[22] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0,  4,  0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0);

    reset_n = 1'b0;
    rd_addr = '0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      wr_en       = vecs[i].we;
      wr_addr     = {vecs[i].wa1, vecs[i].wa0};
      wr_data     = {vecs[i].wd1, vecs[i].wd0};
      rd_addr     = {vecs[i].ra1, vecs[i].ra0};
      sb_set_en   = vecs[i].se;
      sb_set_addr = vecs[i].sa;
      sb_flush    = vecs[i].fl;
      @(negedge clk);
      check($sformatf("v%0d rd_data0", i), rd_data[31:0], vecs[i].e0);
      check($sformatf("v%0d rd_data1", i), rd_data[63:32], vecs[i].e1);
      check($sformatf("v%0d rd_busy", i), {30'h0, rd_busy}, {30'h0, vecs[i].eb});
      check($sformatf("v%0d busy_cnt", i), {26'h0, busy_cnt}, {26'h0, vecs[i].ec});
      check($sformatf("v%0d nobypass rd_data0", i), rd_data_nb[31:0], vecs[i].enb);
      $display("vec %0d rd0=%h rd1=%h busy=%b cnt=%0d nb_rd0=%h", i,
               rd_data[31:0], rd_data[63:32], rd_busy, busy_cnt, rd_data_nb[31:0]);
    end

    // Asynchronous reset mid-cycle: x4 busy, then reset_n drops away from any edge.
    @(posedge clk);
    #1;
    drive_idle();
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    rd_addr = {5'd5, 5'd4};
    @(posedge clk);
    #1;
    drive_idle();
    check("set x4 busy_cnt", {26'h0, busy_cnt}, 32'd1);
    check("set x4 rd_busy", {30'h0, rd_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy_cnt", {26'h0, busy_cnt}, 32'd0);
    check("async reset rd_busy", {30'h0, rd_busy}, 32'd0);
    check("async reset x5", rd_data[63:32], 32'h0);
    $display("async reset cnt=%0d busy=%b x5=%h", busy_cnt, rd_busy, rd_data[63:32]);

    // A write and set presented while reset is held must be discarded.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'hCAFEF00D};
    sb_set_en = 1'b1; sb_set_addr = 5'd6;
    @(posedge clk);
    #1;
    drive_idle();
    rd_addr = {5'd6, 5'd6};
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("write during reset x6", rd_data[31:0], 32'h0);
    check("set during reset busy_cnt", {26'h0, busy_cnt}, 32'd0);
    $display("after reset x6=%h cnt=%0d", rd_data[31:0], busy_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
